monolith_bricks_pipe: RTL and testbench



---
 rtl/monolith_bricks_pipe_if.sv | 39 +++
 rtl/monolith_bricks_pipe.sv | 134 +++++++++++++
 tb/tb_monolith_bricks_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/monolith_bricks_pipe_if.sv
// Valid/ready stream bundle for the Bricks layer: state vector in, state vector out.
// With MONOLITH_BRICKS_TAG_EN defined a sideband tag travels alongside each vector.
interface monolith_bricks_pipe_if #(
    parameter int unsigned WORD_WIDTH = 31,
    parameter int unsigned STATE_SIZE = 16
`ifdef MONOLITH_BRICKS_TAG_EN
    ,
    parameter int unsigned TAG_WIDTH  = 8
`endif
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out;
`ifdef MONOLITH_BRICKS_TAG_EN
    logic [TAG_WIDTH-1:0]                  in_tag;
    logic [TAG_WIDTH-1:0]                  out_tag;

    modport master (
        output in_valid, state_in, in_tag, out_ready,
        input  in_ready, out_valid, state_out, out_tag
    );
    modport slave (
        input  in_valid, state_in, in_tag, out_ready,
        output in_ready, out_valid, state_out, out_tag
    );
`else
    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );
    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
`endif
endinterface

// File: rtl/monolith_bricks_pipe.sv
// Pipelined Bricks layer over the Mersenne field p = 2^WORD_WIDTH - 1.
// out[0] = in[0], out[i] = in[i] + in[i-1]^2 mod p. Optional tag sideband: MONOLITH_BRICKS_TAG_EN.
module monolith_bricks_pipe #(
    parameter int unsigned WORD_WIDTH = 31,
    parameter int unsigned STATE_SIZE = 16,
    parameter int unsigned MUL_STAGES = 2
`ifdef MONOLITH_BRICKS_TAG_EN
    ,
    parameter int unsigned TAG_WIDTH  = 8
`endif
) (
    input logic                   clk,
    input logic                   reset,
    monolith_bricks_pipe_if.slave bus
);
    localparam int unsigned W   = WORD_WIDTH;
    localparam int unsigned S   = STATE_SIZE;
    localparam int unsigned LAT = MUL_STAGES + 1;
    localparam logic [W-1:0] P  = {W{1'b1}};

    typedef logic [W-1:0]              word_t;
    typedef logic [2*W-1:0]            dword_t;
    typedef logic [S-1:0][W-1:0]       vec_t;
    typedef logic [S-1:0][2*W-1:0]     sqvec_t;

    // Mersenne reduction of a double-width square; result is canonical.
    function automatic word_t fold_sq(input dword_t sq);
        logic [W:0] r1;
        word_t      r2;
        r1 = {1'b0, sq[W-1:0]} + {1'b0, sq[2*W-1:W]};
        r2 = r1[W-1:0] + W'(r1[W]);
        return (r2 == P) ? '0 : r2;
    endfunction

    function automatic word_t add_mod(input word_t a, input word_t b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, P}) ? W'(s - {1'b0, P}) : s[W-1:0];
    endfunction

    logic [LAT-1:0] valid_q, valid_d;
    logic [LAT-1:0] load;
    logic [LAT-1:0] src_v;
    logic [LAT-1:0] adv;
    logic           in_ready_c;
    logic           in_fire;

    // A stage may load if the output drains or any stage at or beyond it is empty.
    for (genvar k = 0; k < LAT; k++) begin : g_load
        assign load[k] = bus.out_ready || !(&valid_q[LAT-1:k]);
    end

    assign in_ready_c = !reset && load[0];
    assign in_fire    = bus.in_valid && in_ready_c;
    assign src_v      = {valid_q[LAT-2:0], in_fire};
    assign adv        = load & src_v;
    assign valid_d    = (load & src_v) | (~load & valid_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Stage 0: canonicalise inputs and square the left neighbour of every lane.
    vec_t   cin;
    sqvec_t sq_in;
    for (genvar i = 0; i < S; i++) begin : g_cin
        assign cin[i] = (bus.state_in[i] == P) ? '0 : bus.state_in[i];
    end
    assign sq_in[0] = '0;
    for (genvar i = 1; i < S; i++) begin : g_sq
        assign sq_in[i] = dword_t'(cin[i-1]) * dword_t'(cin[i-1]);
    end

    sqvec_t sq_q  [MUL_STAGES];
    vec_t   add_q [MUL_STAGES];

    always_ff @(posedge clk) begin
        if (adv[0]) begin
            sq_q[0]  <= sq_in;
            add_q[0] <= cin;
        end
    end

    // Remaining multiplier stages only carry the product forward.
    for (genvar k = 1; k < MUL_STAGES; k++) begin : g_mul
        always_ff @(posedge clk) begin
            if (adv[k]) begin
                sq_q[k]  <= sq_q[k-1];
                add_q[k] <= add_q[k-1];
            end
        end
    end

    vec_t out_d, out_q;
    for (genvar i = 0; i < S; i++) begin : g_res
        assign out_d[i] = add_mod(add_q[MUL_STAGES-1][i], fold_sq(sq_q[MUL_STAGES-1][i]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else if (adv[LAT-1]) begin
            out_q <= out_d;
        end
    end

`ifdef MONOLITH_BRICKS_TAG_EN
    logic [TAG_WIDTH-1:0] tag_q   [LAT];
    logic [TAG_WIDTH-1:0] tag_src [LAT];
    assign tag_src[0] = bus.in_tag;
    for (genvar k = 1; k < LAT; k++) begin : g_tag_src
        assign tag_src[k] = tag_q[k-1];
    end
    for (genvar k = 0; k < LAT; k++) begin : g_tag
        always_ff @(posedge clk) begin
            if (reset) begin
                tag_q[k] <= '0;
            end else if (adv[k]) begin
                tag_q[k] <= tag_src[k];
            end
        end
    end
    assign bus.out_tag = tag_q[LAT-1];
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q[LAT-1] && !reset;
    assign bus.state_out = out_q;

endmodule

// File: tb/tb_monolith_bricks_pipe.sv
// Scoreboard bench for monolith_bricks_pipe: driver pushes model results, monitor pops on output transfers.
module tb_monolith_bricks_pipe;
    localparam int unsigned W   = 31;
    localparam int unsigned S   = 16;
    localparam int unsigned LAT = 3;
    localparam logic [W-1:0] P   = 31'h7FFF_FFFF;
    localparam logic [W-1:0] PM1 = 31'h7FFF_FFFE;
    localparam longint unsigned PL = 64'd2147483647;

    typedef logic [S-1:0][W-1:0] vec_t;
    typedef struct {
        vec_t       v;
        logic [7:0] tag;
        int         acc;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef MONOLITH_BRICKS_TAG_EN
    monolith_bricks_pipe_if #(.WORD_WIDTH(W), .STATE_SIZE(S), .TAG_WIDTH(8)) bus ();
`else
    monolith_bricks_pipe_if #(.WORD_WIDTH(W), .STATE_SIZE(S)) bus ();
`endif

    monolith_bricks_pipe #(
        .WORD_WIDTH(W),
        .STATE_SIZE(S),
        .MUL_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference: plain modular arithmetic on the canonical input values.
    function automatic vec_t model(input vec_t x);
        longint unsigned a [S];
        vec_t r;
        for (int i = 0; i < S; i++) a[i] = longint'(x[i]) % PL;
        r[0] = W'(a[0]);
        for (int i = 1; i < S; i++) r[i] = W'((a[i] + (a[i-1] * a[i-1]) % PL) % PL);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < S; i++) begin
            case ($urandom_range(0, 7))
                0:       v[i] = P;
                1:       v[i] = PM1;
                2:       v[i] = '0;
                default: v[i] = W'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input vec_t d, input logic [7:0] tg, input logic ordy,
                         input vec_t ev, input bit lat, output bit fired);
        exp_t it;
        @(negedge clk);
        bus.in_valid  = v;
        bus.state_in  = d;
        bus.out_ready = ordy;
`ifdef MONOLITH_BRICKS_TAG_EN
        bus.in_tag    = tg;
`endif
        #1;
        fired = v && bus.in_ready;
        if (fired) begin
            it.v = ev; it.tag = tg; it.acc = cyc; it.lat = lat;
            exp_q.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        bit f;
        for (int j = 0; j < n; j++) drive(1'b0, '0, 8'h00, 1'b1, '0, 1'b0, f);
    endtask

    // Monitor: compares every output transfer and checks hold-while-stalled.
    bit   prev_stall = 1'b0;
    vec_t prev_data;
    always @(negedge clk) begin
        exp_t it;
        #2;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!bus.out_valid || bus.state_out !== prev_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data changed=%0b", bus.out_valid, bus.state_out !== prev_data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing outstanding", bus.state_out);
                end else begin
                    it = exp_q.pop_front();
                    if (bus.state_out !== it.v) begin
                        errors++;
                        $display("FAIL out_data #%0d: got %h expected %h", out_cnt, bus.state_out, it.v);
                    end
                    if (it.lat) chk("latency", longint'(cyc - it.acc), longint'(LAT));
`ifdef MONOLITH_BRICKS_TAG_EN
                    chk("out_tag", longint'(bus.out_tag), longint'(it.tag));
`endif
                end
                out_cnt++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.state_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vin, vexp, r1, r2;
        vec_t bp [5];
        bit   f;
        int   idx, c0, sent, budget;
        vec_t rv;
        logic [7:0] rt;

        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.state_in  = '0;
`ifdef MONOLITH_BRICKS_TAG_EN
        bus.in_tag    = '0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", longint'(bus.in_ready), 1);
        chk("post_rst_out_valid", longint'(bus.out_valid), 0);
        chk("post_rst_state_out_zero", longint'(bus.state_out == '0), 1);
`ifdef MONOLITH_BRICKS_TAG_EN
        chk("post_rst_out_tag", longint'(bus.out_tag), 0);
`endif

        // Directed vectors streamed back to back with fixed expected results.
        vin = '0; vin[0] = 31'd1; vin[1] = 31'd2; vin[2] = 31'd3; vin[3] = 31'd4;
        vexp = '0; vexp[0] = 31'd1; vexp[1] = 31'd3; vexp[2] = 31'd7; vexp[3] = 31'd13; vexp[4] = 31'd16;
        drive(1'b1, vin, 8'h01, 1'b1, vexp, 1'b1, f);
        chk("basic_accept", longint'(f), 1);
        vin = '0; vin[0] = PM1; vin[1] = PM1;
        vexp = '0; vexp[0] = PM1; vexp[1] = '0; vexp[2] = 31'd1;
        drive(1'b1, vin, 8'h02, 1'b1, vexp, 1'b1, f);
        chk("wrap_accept", longint'(f), 1);
        vin = '0; vin[0] = P; vin[1] = P;
        vexp = '0;
        drive(1'b1, vin, 8'h03, 1'b1, vexp, 1'b1, f);
        chk("noncanon_accept", longint'(f), 1);
        idle(6);
        chk("directed_drained", longint'(exp_q.size()), 0);

        // Backpressure: only LAT vectors fit, then a gapless drain of all five.
        for (int j = 0; j < 5; j++) bp[j] = rand_vec();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, bp[idx], 8'(8'h40 + idx), 1'b0, model(bp[idx]), 1'b0, f);
            if (f) idx++;
        end
        chk("bp_accepted", longint'(idx), 3);
        chk("bp_in_ready_low", longint'(bus.in_ready), 0);
        chk("bp_out_valid_high", longint'(bus.out_valid), 1);
        c0 = out_cnt;
        for (int j = 0; j < 5; j++) begin
            drive(idx < 5, bp[(idx < 5) ? idx : 0], 8'(8'h40 + idx), 1'b1,
                  model(bp[(idx < 5) ? idx : 0]), 1'b0, f);
            if (f) idx++;
            #2;
            chk($sformatf("bp_stream_%0d", j), longint'(out_cnt - c0), longint'(j + 1));
        end
        chk("bp_all_accepted", longint'(idx), 5);
        idle(4);

        // Random stream with random valid/ready.
        sent = 0; budget = 0;
        rv = rand_vec(); rt = 8'($urandom);
        while (sent < 1000 && budget < 20000) begin
            drive(1'($urandom_range(0, 1)), rv, rt, 1'($urandom_range(0, 1)), model(rv), 1'b0, f);
            if (f) begin
                sent++;
                rv = rand_vec(); rt = 8'($urandom);
            end
            budget++;
        end
        chk("rand_all_sent", longint'(sent), 1000);
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            drive(1'b0, '0, 8'h00, 1'b1, '0, 1'b0, f);
            budget++;
        end
        chk("rand_drained", longint'(exp_q.size()), 0);

        // Reset with two vectors in flight: both must vanish.
        r1 = rand_vec(); r2 = rand_vec();
        drive(1'b1, r1, 8'h5A, 1'b0, model(r1), 1'b0, f);
        drive(1'b1, r2, 8'h5B, 1'b0, model(r2), 1'b0, f);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk("midrst_in_ready", longint'(bus.in_ready), 0);
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("after_rst_out_valid", longint'(bus.out_valid), 0);
        c0 = out_cnt;
        idle(10);
        chk("no_stale_output", longint'(out_cnt - c0), 0);

        // Tagged vectors must come out paired with their data.
        vin = rand_vec(); drive(1'b1, vin, 8'h11, 1'b1, model(vin), 1'b1, f);
        chk("tag11_accept", longint'(f), 1);
        vin = rand_vec(); drive(1'b1, vin, 8'h22, 1'b1, model(vin), 1'b1, f);
        chk("tag22_accept", longint'(f), 1);
        vin = rand_vec(); drive(1'b1, vin, 8'h33, 1'b1, model(vin), 1'b1, f);
        chk("tag33_accept", longint'(f), 1);
        idle(6);
        chk("final_drained", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
